// File: rtl/tpu_sequencer.sv
// Sequencer for a weight-stationary systolic array: loads N weight rows, streams
// the input rows, then writes back results as they leave the array pipeline.
module tpu_sequencer #(
    parameter int N    = 4,
    parameter int AW   = 8,
    parameter int KW   = 8,
    parameter int PIPE = 2*N
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] w_base,
    input  logic [AW-1:0] x_base,
    input  logic [AW-1:0] y_base,
    input  logic [KW-1:0] rows,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    output logic          wt_load,
    output logic          x_valid,
    output logic          acc_clear,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int LW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t          state;
    logic [LW-1:0]   wcnt;
    logic [KW-1:0]   xcnt;
    logic [KW-1:0]   ycnt;
    logic [KW-1:0]   rows_q;
    logic [AW-1:0]   x_q;
    logic [PIPE-1:0] wr_pipe;

    // Result strobe is the input-row valid delayed through the array latency.
    assign wr_en = wr_pipe[PIPE-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_pipe <= '0;
        end else begin
            wr_pipe[0] <= x_valid;
            for (int k = 1; k < PIPE; k++) begin
                wr_pipe[k] <= wr_pipe[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wcnt      <= '0;
            xcnt      <= '0;
            ycnt      <= '0;
            rows_q    <= '0;
            x_q       <= '0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            wt_load   <= 1'b0;
            x_valid   <= 1'b0;
            acc_clear <= 1'b0;
            wr_addr   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            acc_clear <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            wt_load   <= rd_en && (state == LOAD_W);
            x_valid   <= rd_en && (state == STREAM);

            // Write address and write count advance on every result, whatever the state.
            if (wr_en) begin
                wr_addr <= wr_addr + AW'(1);
                ycnt    <= ycnt + KW'(1);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        if (rows == '0) begin
                            err <= 1'b1;
                        end else begin
                            state     <= LOAD_W;
                            busy      <= 1'b1;
                            acc_clear <= 1'b1;
                            rd_en     <= 1'b1;
                            rd_addr   <= w_base;
                            wcnt      <= '0;
                            xcnt      <= '0;
                            ycnt      <= '0;
                            x_q       <= x_base;
                            rows_q    <= rows;
                            wr_addr   <= y_base;
                        end
                    end
                end
                LOAD_W: begin
                    if (wcnt == LW'(N-1)) begin
                        state   <= STREAM;
                        rd_addr <= x_q;
                    end else begin
                        wcnt    <= wcnt + LW'(1);
                        rd_addr <= rd_addr + AW'(1);
                    end
                end
                STREAM: begin
                    if (xcnt == rows_q - KW'(1)) begin
                        state   <= DRAIN;
                        rd_en   <= 1'b0;
                        rd_addr <= '0;
                    end else begin
                        xcnt    <= xcnt + KW'(1);
                        rd_addr <= rd_addr + AW'(1);
                    end
                end
                DRAIN: begin
                    // Leave once the last result of the pass has been written.
                    if (wr_en && (ycnt == rows_q - KW'(1))) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    rd_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_sequencer.sv
// Scoreboard bench for tpu_sequencer: per-cycle control timing plus queued
// read/write address expectations for each pass.
module tb_tpu_sequencer;

    localparam int N    = 4;
    localparam int AW   = 8;
    localparam int KW   = 8;
    localparam int PIPE = 2*N;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] w_base = '0;
    logic [AW-1:0] x_base = '0;
    logic [AW-1:0] y_base = '0;
    logic [KW-1:0] rows = '0;
    logic          rd_en, wt_load, x_valid, acc_clear, wr_en, busy, done, err;
    logic [AW-1:0] rd_addr, wr_addr;

    int vectors = 0;
    int errors  = 0;

    logic [AW-1:0] rdq[$];
    logic [AW-1:0] wrq[$];

    tpu_sequencer #(.N(N), .AW(AW), .KW(KW), .PIPE(PIPE)) dut (
        .clk(clk), .reset(reset), .start(start),
        .w_base(w_base), .x_base(x_base), .y_base(y_base), .rows(rows),
        .rd_en(rd_en), .rd_addr(rd_addr), .wt_load(wt_load), .x_valid(x_valid),
        .acc_clear(acc_clear), .wr_en(wr_en), .wr_addr(wr_addr),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ctl_now();
        return {acc_clear, rd_en, wt_load, x_valid, wr_en, busy, done, err};
    endfunction

    // Expected control outputs c cycles after start was presented, for a pass of r rows.
    function automatic logic [7:0] exp_ctl(int c, int r);
        int d;
        d = N + 2 + PIPE + r;
        exp_ctl[7] = (c == 1);
        exp_ctl[6] = (c >= 1) && (c <= N + r);
        exp_ctl[5] = (c >= 2) && (c <= N + 1);
        exp_ctl[4] = (c >= N + 2) && (c <= N + 1 + r);
        exp_ctl[3] = (c >= N + 2 + PIPE) && (c <= N + 1 + PIPE + r);
        exp_ctl[2] = (c >= 1) && (c <= d);
        exp_ctl[1] = (c == d);
        exp_ctl[0] = 1'b0;
    endfunction

    task automatic push_pass(logic [AW-1:0] wb, logic [AW-1:0] xb, logic [AW-1:0] yb, int r);
        for (int i = 0; i < N; i++) rdq.push_back(wb + AW'(i));
        for (int j = 0; j < r; j++) rdq.push_back(xb + AW'(j));
        for (int m = 0; m < r; m++) wrq.push_back(yb + AW'(m));
    endtask

    task automatic test_reset();
        logic [2*AW+7:0] got;
        reset = 1'b0;
        start = 1'b1;
        rows  = 8'd3;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            got = {ctl_now(), rd_addr, wr_addr};
            vectors++;
            if (got !== '0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: got %h expected 0", c, got);
            end
        end
        start = 1'b0;
        reset = 1'b1;
    endtask

    // One full pass with optional ignored start pulses at cycles ign_a/ign_b.
    task automatic run_pass(string name, logic [AW-1:0] wb, logic [AW-1:0] xb,
                            logic [AW-1:0] yb, int r, int ign_a, int ign_b);
        int d, nwr, ndone;
        logic [7:0] got, expv;
        logic [AW-1:0] a;
        d = N + 2 + PIPE + r;
        nwr = 0;
        ndone = 0;
        for (int c = 0; c <= d + 2; c++) begin
            got  = ctl_now();
            expv = exp_ctl(c, r);
            vectors++;
            if (got !== expv) begin
                errors++;
                $display("FAIL %s ctl cycle %0d: got %b expected %b", name, c, got, expv);
            end
            if (rd_en === 1'b1) begin
                vectors++;
                if (rdq.size() == 0) begin
                    errors++;
                    $display("FAIL %s rd_addr cycle %0d: got %h, none expected", name, c, rd_addr);
                end else begin
                    a = rdq.pop_front();
                    if (rd_addr !== a) begin
                        errors++;
                        $display("FAIL %s rd_addr cycle %0d: got %h expected %h", name, c, rd_addr, a);
                    end
                end
            end
            if (wr_en === 1'b1) begin
                nwr++;
                vectors++;
                if (wrq.size() == 0) begin
                    errors++;
                    $display("FAIL %s wr_addr cycle %0d: got %h, none expected", name, c, wr_addr);
                end else begin
                    a = wrq.pop_front();
                    if (wr_addr !== a) begin
                        errors++;
                        $display("FAIL %s wr_addr cycle %0d: got %h expected %h", name, c, wr_addr, a);
                    end
                end
            end
            if (done === 1'b1) ndone++;
            if (c == 0) begin
                start  = 1'b1;
                w_base = wb;
                x_base = xb;
                y_base = yb;
                rows   = KW'(r);
                push_pass(wb, xb, yb, r);
            end else begin
                start  = (c == ign_a) || (c == ign_b);
                w_base = AW'($urandom);
                x_base = AW'($urandom);
                y_base = AW'($urandom);
                rows   = KW'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0;
        vectors++;
        if (nwr != r || ndone != 1 || rdq.size() != 0 || wrq.size() != 0) begin
            errors++;
            $display("FAIL %s totals: wr=%0d done=%0d rdq=%0d wrq=%0d expected wr=%0d done=1 empty queues",
                     name, nwr, ndone, rdq.size(), wrq.size(), r);
        end
        rdq.delete();
        wrq.delete();
    endtask

    task automatic test_basic();
        run_pass("basic", 8'h10, 8'h20, 8'h40, 3, -1, -1);
    endtask

    task automatic test_err();
        logic [7:0] got, expv;
        for (int c = 0; c < 4; c++) begin
            got  = ctl_now();
            expv = (c == 1) ? 8'h01 : 8'h00;
            vectors++;
            if (got !== expv) begin
                errors++;
                $display("FAIL err_rows0 cycle %0d: got %b expected %b", c, got, expv);
            end
            start = (c == 0);
            rows  = '0;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_wrap();
        run_pass("wrap", 8'hFC, 8'hFE, 8'hFF, 4, -1, -1);
    endtask

    task automatic test_start_ignored();
        run_pass("start_ignored", 8'h10, 8'h20, 8'h40, 3, 3, 10);
        run_pass("start_ignored_r9", 8'h00, 8'h50, 8'h60, 9, 3, 10);
    endtask

    task automatic test_reset_mid();
        logic [7:0] got, expv;
        logic [2*AW+7:0] all;
        for (int c = 0; c <= 7; c++) begin
            got  = ctl_now();
            expv = exp_ctl(c, 3);
            vectors++;
            if (got !== expv) begin
                errors++;
                $display("FAIL reset_mid ctl cycle %0d: got %b expected %b", c, got, expv);
            end
            start  = (c == 0);
            w_base = 8'h10;
            x_base = 8'h20;
            y_base = 8'h40;
            rows   = 8'd3;
            if (c < 7) @(negedge clk);
        end
        start = 1'b0;
        reset = 1'b0;
        #1;
        all = {ctl_now(), rd_addr, wr_addr};
        vectors++;
        if (all !== '0) begin
            errors++;
            $display("FAIL reset_mid immediate: got %h expected 0", all);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            all = {ctl_now(), rd_addr, wr_addr};
            vectors++;
            if (all !== '0) begin
                errors++;
                $display("FAIL reset_mid held cycle %0d: got %h expected 0", c, all);
            end
        end
        reset = 1'b1;
        run_pass("reset_restart", 8'h10, 8'h20, 8'h40, 3, -1, -1);
    endtask

    task automatic test_back_to_back();
        int r, d, nwr, ndone;
        logic [7:0] got, expv;
        logic [AW-1:0] a;
        r = 255;
        d = N + 2 + PIPE + r;
        nwr = 0;
        ndone = 0;
        for (int c = 0; c <= 2*d + 3; c++) begin
            got  = ctl_now();
            expv = (c <= d) ? exp_ctl(c, r) : exp_ctl(c - d - 1, r);
            vectors++;
            if (got !== expv) begin
                errors++;
                $display("FAIL b2b ctl cycle %0d: got %b expected %b", c, got, expv);
            end
            if (rd_en === 1'b1) begin
                vectors++;
                a = (rdq.size() != 0) ? rdq.pop_front() : ~rd_addr;
                if (rd_addr !== a) begin
                    errors++;
                    $display("FAIL b2b rd_addr cycle %0d: got %h expected %h", c, rd_addr, a);
                end
            end
            if (wr_en === 1'b1) begin
                nwr++;
                vectors++;
                a = (wrq.size() != 0) ? wrq.pop_front() : ~wr_addr;
                if (wr_addr !== a) begin
                    errors++;
                    $display("FAIL b2b wr_addr cycle %0d: got %h expected %h", c, wr_addr, a);
                end
            end
            if (done === 1'b1) ndone++;
            start = 1'b0;
            if (c == 0) begin
                start  = 1'b1;
                w_base = 8'h00;
                x_base = 8'h30;
                y_base = 8'h80;
                rows   = KW'(r);
                push_pass(8'h00, 8'h30, 8'h80, r);
            end else if (c == d + 1) begin
                start  = 1'b1;
                w_base = 8'hF0;
                x_base = 8'h05;
                y_base = 8'h10;
                rows   = KW'(r);
                push_pass(8'hF0, 8'h05, 8'h10, r);
            end
            @(negedge clk);
        end
        start = 1'b0;
        vectors++;
        if (nwr != 2*r || ndone != 2 || rdq.size() != 0 || wrq.size() != 0) begin
            errors++;
            $display("FAIL b2b totals: wr=%0d done=%0d rdq=%0d wrq=%0d expected wr=%0d done=2 empty queues",
                     nwr, ndone, rdq.size(), wrq.size(), 2*r);
        end
        rdq.delete();
        wrq.delete();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_err();
        test_wrap();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
